// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard monitor.
//   - ps2_state_e    : receive-frame FSM states
//   - PS2_PREFIX_*   : extended / release prefix bytes
//   - SEG_GLYPH      : hex digit -> active-low 7-seg pattern, bit 0 = segment a
//   - clog2          : counter width able to hold 0..value-1 (minimum 1)
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

   localparam logic [6:0] SEG_GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width = width + 1;
      return width;
   endfunction

endpackage

// File: rtl/ps2_kbd_monitor_if.sv
// Scan-code report bus of the keyboard monitor.
//   code_valid  : one-cycle strobe per completed (non-prefix) code
//   code        : last completed scan code
//   ledreleased : last code was preceded by F0
//   ledextended : last code was preceded by E0
//   parity_err  : sticky frame error flag
// master = producer (ps2_kbd_monitor), slave = consumer.
interface ps2_kbd_monitor_if;
   logic       code_valid;
   logic [7:0] code;
   logic       ledreleased;
   logic       ledextended;
   logic       parity_err;

   modport master (output code_valid, code, ledreleased, ledextended, parity_err);
   modport slave  (input  code_valid, code, ledreleased, ledextended, parity_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-FF synchronisers, ps2clk glitch filter, frame FSM.
// Optional frame watchdog enabled by macro PS2_TIMEOUT_EN.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   ps2clk, ps2data   : raw asynchronous pad inputs
//   rx_byte           : last received data byte
//   byte_valid        : one-cycle strobe, good frame received
//   frame_err         : one-cycle strobe, parity or stop-bit error
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (fall with data 0)
// ST_DATA   | shifting 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and odd parity
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int WD_CYCLES  = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2clk,
   input  logic       ps2data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);
   localparam int FLTW = clog2(FILTER_LEN);

   logic [1:0]      clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
   logic            flt_q, flt_d, flt_prev_q, flt_prev_d;
   logic [FLTW-1:0] flt_cnt_q, flt_cnt_d;
   ps2_state_e      state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic            byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
   logic            fall, din, timeout;

   // The filter reloads while the sample matches the filtered level, so a
   // change is accepted only after FILTER_LEN consecutive differing samples.
   always_comb begin
      clk_sync_d  = {clk_sync_q[0], ps2clk};
      data_sync_d = {data_sync_q[0], ps2data};
      flt_d       = flt_q;
      flt_prev_d  = flt_q;
      flt_cnt_d   = flt_cnt_q;
      if (clk_sync_q[1] == flt_q) begin
         flt_cnt_d = FLTW'(FILTER_LEN - 1);
      end else if (flt_cnt_q == '0) begin
         flt_d     = clk_sync_q[1];
         flt_cnt_d = FLTW'(FILTER_LEN - 1);
      end else begin
         flt_cnt_d = flt_cnt_q - FLTW'(1);
      end
   end

   assign fall = flt_prev_q & ~flt_q;
   assign din  = data_sync_q[1];

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!din) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d = {din, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
               else bit_cnt_d = bit_cnt_q + 3'd1;
            end
            ST_PARITY: begin
               par_d   = din;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (din && ((^shift_q) ^ par_q)) byte_valid_d = 1'b1;
               else frame_err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (timeout) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q   <= 2'b11;
         data_sync_q  <= 2'b11;
         flt_q        <= 1'b1;
         flt_prev_q   <= 1'b1;
         flt_cnt_q    <= FLTW'(FILTER_LEN - 1);
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         par_q        <= 1'b0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         data_sync_q  <= data_sync_d;
         flt_q        <= flt_d;
         flt_prev_q   <= flt_prev_d;
         flt_cnt_q    <= flt_cnt_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

`ifdef PS2_TIMEOUT_EN
   localparam int WDW = clog2(WD_CYCLES);
   logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

   // Down-counter restarted by every fall; it rests at zero, which only
   // matters when a frame is in progress.
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (fall) wd_cnt_d = WDW'(WD_CYCLES - 1);
      else if (wd_cnt_q != '0) wd_cnt_d = wd_cnt_q - WDW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) wd_cnt_q <= '0;
      else wd_cnt_q <= wd_cnt_d;
   end

   assign timeout = (wd_cnt_q == '0) && (state_q != ST_IDLE);
`else
   logic unused_wd_cfg;
   assign unused_wd_cfg = (WD_CYCLES > 0);
   assign timeout       = 1'b0;
`endif

   assign rx_byte    = shift_q;
   assign byte_valid = byte_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_kbd_monitor.sv
// PS/2 keyboard scan-code monitor with multiplexed 7-segment history display.
// Optional frame watchdog in ps2_rx enabled by macro PS2_TIMEOUT_EN.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   ps2clk, ps2data : raw PS/2 pad inputs
//   an              : digit anodes, active low, one low at a time
//   seg             : segments a..g (seg[0]=a), active low
//   kbd             : scan-code report bus (code, strobe, LEDs, parity_err)
// Digit 0 is the low nibble of the newest code; history depth NDIGITS/2 bytes.
module ps2_kbd_monitor
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int SCAN_HZ    = 1000,
   parameter int NDIGITS    = 4,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ps2clk,
   input  logic               ps2data,
   output logic [NDIGITS-1:0] an,
   output logic [6:0]         seg,
   ps2_kbd_monitor_if.master  kbd
);
   localparam int HW        = NDIGITS * 4;
   localparam int IDXW      = clog2(NDIGITS);
   localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
   localparam int SCW       = clog2(SCAN_DIV);
   localparam int WD_CYCLES = (CLK_HZ / 1000000) * TIMEOUT_US;

   logic [7:0]         rx_byte;
   logic               byte_valid, frame_err;

   logic [7:0]         code_q, code_d;
   logic               code_valid_q, code_valid_d;
   logic               led_ext_q, led_ext_d, led_rel_q, led_rel_d;
   logic               pend_ext_q, pend_ext_d, pend_rel_q, pend_rel_d;
   logic               perr_q, perr_d;
   logic [HW-1:0]      hist_q, hist_d;
   logic [SCW-1:0]     scan_cnt_q, scan_cnt_d;
   logic [IDXW-1:0]    idx_q, idx_d;
   logic [NDIGITS-1:0] an_q, an_d;
   logic [6:0]         seg_q, seg_d;

   ps2_rx #(
      .FILTER_LEN (FILTER_LEN),
      .WD_CYCLES  (WD_CYCLES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2clk     (ps2clk),
      .ps2data    (ps2data),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   always_comb begin
      code_d       = code_q;
      code_valid_d = 1'b0;
      led_ext_d    = led_ext_q;
      led_rel_d    = led_rel_q;
      pend_ext_d   = pend_ext_q;
      pend_rel_d   = pend_rel_q;
      perr_d       = perr_q | frame_err;
      hist_d       = hist_q;
      if (byte_valid) begin
         if (rx_byte == PS2_PREFIX_EXT) begin
            pend_ext_d = 1'b1;
         end else if (rx_byte == PS2_PREFIX_REL) begin
            pend_rel_d = 1'b1;
         end else begin
            code_d       = rx_byte;
            code_valid_d = 1'b1;
            led_ext_d    = pend_ext_q;
            led_rel_d    = pend_rel_q;
            pend_ext_d   = 1'b0;
            pend_rel_d   = 1'b0;
            hist_d       = (hist_q << 8) | HW'(rx_byte);
         end
      end
   end

   // an and seg are both registered from the same index, so they switch on
   // the same edge and no digit ever shows its neighbour's glyph.
   always_comb begin
      scan_cnt_d = scan_cnt_q - SCW'(1);
      idx_d      = idx_q;
      if (scan_cnt_q == '0) begin
         scan_cnt_d = SCW'(SCAN_DIV - 1);
         idx_d      = (idx_q == IDXW'(NDIGITS - 1)) ? '0 : idx_q + IDXW'(1);
      end
      an_d  = ~(NDIGITS'(1) << idx_q);
      seg_d = SEG_GLYPH[hist_q[4*idx_q +: 4]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q       <= 8'h00;
         code_valid_q <= 1'b0;
         led_ext_q    <= 1'b0;
         led_rel_q    <= 1'b0;
         pend_ext_q   <= 1'b0;
         pend_rel_q   <= 1'b0;
         perr_q       <= 1'b0;
         hist_q       <= '0;
         scan_cnt_q   <= SCW'(SCAN_DIV - 1);
         idx_q        <= '0;
         an_q         <= '1;
         seg_q        <= 7'h7F;
      end else begin
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         led_ext_q    <= led_ext_d;
         led_rel_q    <= led_rel_d;
         pend_ext_q   <= pend_ext_d;
         pend_rel_q   <= pend_rel_d;
         perr_q       <= perr_d;
         hist_q       <= hist_d;
         scan_cnt_q   <= scan_cnt_d;
         idx_q        <= idx_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
      end
   end

   assign an              = an_q;
   assign seg             = seg_q;
   assign kbd.code_valid  = code_valid_q;
   assign kbd.code        = code_q;
   assign kbd.ledreleased = led_rel_q;
   assign kbd.ledextended = led_ext_q;
   assign kbd.parity_err  = perr_q;

endmodule

// File: tb/tb_ps2_kbd_monitor.sv
// Scoreboard bench for ps2_kbd_monitor: a frame-level keyboard model predicts
// each reported code; an independent monitor pops and compares on code_valid.
module tb_ps2_kbd_monitor;
   localparam int CLK_HZ     = 1000000;
   localparam int SCAN_HZ    = 100000;
   localparam int NDIGITS    = 6;
   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT_US = 200;
   localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
   localparam int HALF       = 20;

   // active-high gfedcba patterns of the hex digits 0..F
   localparam logic [6:0] GLYPH_ON [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               ps2clk = 1'b1;
   logic               ps2data = 1'b1;
   logic [NDIGITS-1:0] an;
   logic [6:0]         seg;

   ps2_kbd_monitor_if kbd_if ();

   ps2_kbd_monitor #(
      .CLK_HZ     (CLK_HZ),
      .SCAN_HZ    (SCAN_HZ),
      .NDIGITS    (NDIGITS),
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_US (TIMEOUT_US)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ps2clk  (ps2clk),
      .ps2data (ps2data),
      .an      (an),
      .seg     (seg),
      .kbd     (kbd_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic mdl_bits[$];
   logic [7:0] mdl_hist[$];
   logic mdl_ext = 1'b0, mdl_rel = 1'b0, mdl_perr = 1'b0;
   int   mdl_valid = 0, mdl_1c = 0, obs_valid = 0, obs_1c = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Keyboard-level model: a byte completes a code unless it is a prefix.
   function automatic void mdl_byte(input logic [7:0] b);
      if (b == 8'hE0) mdl_ext = 1'b1;
      else if (b == 8'hF0) mdl_rel = 1'b1;
      else begin
         exp_q.push_back('{code: b, ext: mdl_ext, rel: mdl_rel});
         mdl_valid++;
         if (b == 8'h1C) mdl_1c++;
         mdl_ext = 1'b0;
         mdl_rel = 1'b0;
         mdl_hist.push_front(b);
         if (mdl_hist.size() > NDIGITS/2) void'(mdl_hist.pop_back());
      end
   endfunction

   // Bit-stream model: idle 1s are ignored, a 0 opens an 11-bit frame.
   function automatic void mdl_fall(input logic b);
      logic [7:0] d;
      int ones;
      if (mdl_bits.size() == 0 && b) return;
      mdl_bits.push_back(b);
      if (mdl_bits.size() == 11) begin
         ones = 0;
         for (int i = 0; i < 8; i++) begin
            d[i] = mdl_bits[1+i];
            ones += int'(mdl_bits[1+i]);
         end
         ones += int'(mdl_bits[9]);
         if (mdl_bits[10] && (ones % 2 == 1)) mdl_byte(d);
         else mdl_perr = 1'b1;
         mdl_bits.delete();
      end
   endfunction

   function automatic logic [6:0] exp_glyph(input int idx);
      logic [7:0] b;
      logic [3:0] n;
      b = (idx/2 < mdl_hist.size()) ? mdl_hist[idx/2] : 8'h00;
      n = (idx % 2 == 1) ? b[7:4] : b[3:0];
      return ~GLYPH_ON[n];
   endfunction

   task automatic ps2_bit(input logic b);
      ps2data = b;
      repeat (HALF) @(posedge clk);
      #1 ps2clk = 1'b0;
      mdl_fall(b);
      repeat (HALF) @(posedge clk);
      #1 ps2clk = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(~(^b) ^ bad);
      ps2_bit(1'b1);
   endtask

   task automatic phase_end(input string name);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (40) @(posedge clk);
      @(negedge clk);
      check({name, "_pending"}, exp_q.size(), 0);
      check({name, "_strobes"}, obs_valid, mdl_valid);
      check({name, "_parity_err"}, 32'(kbd_if.parity_err), 32'(mdl_perr));
   endtask

   task automatic check_display(input string name);
      logic [NDIGITS-1:0] prev_an;
      int prev_idx, since, seen, idx;
      prev_idx = -1;
      since    = 0;
      seen     = 0;
      @(negedge clk);
      prev_an = an;
      for (int c = 0; c < 3*NDIGITS*SCAN_DIV; c++) begin
         @(negedge clk);
         since++;
         if (an !== prev_an) begin
            idx = -1;
            for (int i = 0; i < NDIGITS; i++)
               if (an == ~(NDIGITS'(1) << i)) idx = i;
            check({name, "_an_onehot"}, 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
               if (prev_idx >= 0) begin
                  check({name, "_an_order"}, idx, (prev_idx + 1) % NDIGITS);
                  check({name, "_an_period"}, since, SCAN_DIV);
               end
               check({name, "_seg"}, 32'(seg), 32'(exp_glyph(idx)));
               prev_idx = idx;
               seen++;
            end
            since   = 0;
            prev_an = an;
         end
      end
      check({name, "_digits_seen"}, 32'(seen >= 2*NDIGITS), 32'd1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && kbd_if.code_valid) begin
         obs_valid++;
         if (kbd_if.code == 8'h1C) obs_1c++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_code_valid actual=%0h required=none", kbd_if.code);
         end else begin
            e = exp_q.pop_front();
            check("code", 32'(kbd_if.code), 32'(e.code));
            check("ledextended", 32'(kbd_if.ledextended), 32'(e.ext));
            check("ledreleased", 32'(kbd_if.ledreleased), 32'(e.rel));
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int o1c, m1c, r;
      logic [7:0] b;

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_an", 32'(an), 32'({NDIGITS{1'b1}}));
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_code", 32'(kbd_if.code), 32'h00);
      check("rst_code_valid", 32'(kbd_if.code_valid), 32'd0);
      check("rst_leds", 32'({kbd_if.ledextended, kbd_if.ledreleased}), 32'd0);
      check("rst_parity_err", 32'(kbd_if.parity_err), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);

      send_byte(8'h1C, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      phase_end("make_break");
      check_display("disp_make_break");

      send_byte(8'hE0, 1'b0);
      send_byte(8'h75, 1'b0);
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      phase_end("extended");

      send_byte(8'h1C, 1'b1);
      phase_end("bad_parity");
      check_display("disp_bad_parity");
      send_byte(8'h32, 1'b0);
      phase_end("after_bad");

      for (int g = 0; g < 12; g++) begin
         ps2data = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1 ps2clk = 1'b0;
         repeat (2) @(posedge clk);
         #1 ps2clk = 1'b1;
         repeat (5 + $urandom_range(0, 10)) @(posedge clk);
      end
      ps2data = 1'b1;
      phase_end("glitch");
      send_byte(8'h2A, 1'b0);
      phase_end("post_glitch");

      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      phase_end("three_codes");
      check_display("disp_332211");

      for (int k = 0; k < 24; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) b = 8'hE0;
         else if (r == 1) b = 8'hF0;
         else b = 8'($urandom);
         send_byte(b, ($urandom_range(0, 7) == 0));
      end
      phase_end("random");
      check_display("disp_random");

      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
      repeat (TIMEOUT_US * (CLK_HZ / 1000000) + 100) @(posedge clk);
`ifdef PS2_TIMEOUT_EN
      mdl_bits.delete();
`endif
      o1c = obs_1c;
      m1c = mdl_1c;
      send_byte(8'h1C, 1'b0);
      phase_end("partial_frame");
      check("partial_then_1c", obs_1c - o1c, mdl_1c - m1c);

      #1 rst = 1'b1;
      mdl_bits.delete();
      mdl_hist.delete();
      mdl_ext  = 1'b0;
      mdl_rel  = 1'b0;
      mdl_perr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst2_code", 32'(kbd_if.code), 32'h00);
      check("rst2_parity_err", 32'(kbd_if.parity_err), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      send_byte(8'h1C, 1'b0);
      phase_end("after_reset");
      check_display("disp_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
